ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning RAM data width.
REQ-002 The block SHALL have parameter AW, default 8, meaning RAM address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  synchronous active-high reset.
REQ-004 For each requester x in {0 = CPU, 1 = DMA}, the block SHALL have these ports:
- Req_x  in  1  access request.
- Wr_x  in  1  1 = write, 0 = read.
- Lock_x  in  1  keep ownership for next access.
- Addr_x  in  AW  address.
- Wdata_x  in  DW  write data.
- Gnt_x  out  1  command accepted.
- Rvalid_x  out  1  read data valid.
REQ-005 The block SHALL have these RAM-side and status ports:
- Rdata  out  DW  read data, shared by both requesters.
- Cs  out  1  RAM chip select.
- Wen  out  1  RAM write enable.
- Oen  out  1  RAM output enable.
- Address  out  AW  RAM address.
- DataIn  out  DW  RAM write data.
- DataOut  in  DW  RAM read data.
- Busy  out  1  access in progress.

Function
REQ-006 The FSM SHALL have states IDLE, ACCESS and RESP; every output except Rdata SHALL be registered.
REQ-007 In IDLE, if any Req_x is sampled high at a clock edge, the FSM SHALL go to ACCESS at that edge and latch Wr, Addr and Wdata from the winning requester.
REQ-008 When both requests are high, the winner SHALL be the requester not granted last (round-robin); after reset the CPU (0) wins first.
REQ-009 When the last winner had Lock_x high when it was granted, that requester SHALL win the next contention regardless of round-robin; the lock SHALL hold for one access only.
REQ-010 In ACCESS (exactly one cycle):
- Gnt_winner = 1.
- Cs = 1.
- Wen = latched Wr; Oen = !latched Wr.
- Address = latched address; DataIn = latched data on writes, 0 on reads.
REQ-011 From ACCESS, a write SHALL return to IDLE and a read SHALL go to RESP.
REQ-012 In RESP (one cycle), Rvalid_winner SHALL be 1 and Rdata SHALL be DataOut passed through combinationally; the FSM then returns to IDLE.
REQ-013 Outside ACCESS, the outputs SHALL be Cs = Wen = Oen = 0 and Address = DataIn = 0; both Gnt signals SHALL be 0.
REQ-014 Busy SHALL be 1 in ACCESS and RESP, and 0 in IDLE.
REQ-015 Throughput SHALL be 2 cycles per write and 3 cycles per read, edge to edge; there SHALL be no back-to-back issue without passing through IDLE.
REQ-016 A requester SHALL hold Req_x, Wr_x, Addr_x and Wdata_x stable until Gnt_x; a Req_x dropped before its grant SHALL produce no RAM access.
REQ-017 A Req_x still high in the cycle after Gnt_x SHALL be treated as a new request.
REQ-018 Address values SHALL be forwarded unmodified over the full range 0x00-0xFF, covering both the register region 0x00-0x3F and the general-purpose region 0x40-0xFF.
REQ-019 A request arriving while Busy SHALL wait with no loss and no reordering within a requester.

Reset
REQ-020 While Rst is high at a clock edge, the block SHALL:
- enter IDLE;
- clear all outputs to 0;
- set the round-robin pointer so the CPU wins next;
- clear the lock flag.
REQ-021 Reset asserted in ACCESS or RESP SHALL abandon the access: no Rvalid, and Cs = 0 from the next edge.

Structure
REQ-022 Package ram_arb_pkg SHALL hold:
- the state enum (IDLE, ACCESS, RESP);
- constants NREQ = 2, DW_DEF = 8, AW_DEF = 8.
REQ-023 The round-robin/lock winner selection SHALL be a sub-module ram_arb_rr, taking requests, the last-winner pointer and the lock flag, and returning a one-hot winner.
REQ-024 Total RTL SHALL be 120-400 lines.

Verification
REQ-025 After reset, a single CPU write with Addr 0x12 and Wdata 0xA5 SHALL produce:
- Gnt_0 for one cycle;
- one cycle with Cs = 1, Wen = 1, Oen = 0, Address = 0x12, DataIn = 0xA5;
- no Rvalid.
REQ-026 A CPU read of 0x12 following REQ-025 SHALL produce:
- Oen = 1 for one cycle;
- Rvalid_0 = 1 in the next cycle with Rdata = 0xA5.
REQ-027 With Req_0 and Req_1 held high continuously, writing to 0x40 and 0x41, grants SHALL alternate 0, 1, 0, 1, each two cycles apart.
REQ-028 With Lock_1 = 1 on a DMA grant and both requesting, the next grant SHALL be 1 again, and the following grant SHALL be 0.
REQ-029 A sweep of all addresses 0x00-0xFE, with CPU writes of data equal to the address and reads back, interleaved with DMA reads, SHALL return the matching Rdata on every Rvalid.
REQ-030 Rst asserted in the ACCESS cycle of a read SHALL produce Cs = 0 and no Rvalid on the next edge; Busy = 0, and the next contention SHALL be granted to CPU.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
//   NREQ   : number of requesters (0 = CPU, 1 = DMA)
//   DW_DEF : default RAM data width
//   AW_DEF : default RAM address width
//   arb_state_e : arbiter FSM states
package ram_arb_pkg;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_arb_rr.sv
// Winner selection for the RAM arbiter.
//   req    : per-requester request lines
//   last   : index of the requester granted last
//   lock   : last winner asked to keep ownership for one more access
//   winner : one-hot winner, all zero when nobody requests
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  input  logic            lock,
  output logic [NREQ-1:0] winner
);

  logic pick;

  always_comb begin
    // Under contention a held lock keeps the last winner, otherwise the other one goes.
    pick   = lock ? last : !last;
    winner = req;
    if (req == 2'b11) begin
      winner = pick ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester (CPU/DMA) arbiter in front of a single-port synchronous RAM.
// Ports:
//   Clk, Rst                 : clock and synchronous active-high reset
//   Req_x/Wr_x/Lock_x        : request, write flag, ownership lock (x = 0 CPU, 1 DMA)
//   Addr_x/Wdata_x           : request address and write data
//   Gnt_x                    : command accepted (high during the RAM access cycle)
//   Rvalid_x                 : read data valid on Rdata
//   Rdata                    : shared read data (DataOut passed through while valid)
//   Cs/Wen/Oen/Address/DataIn: RAM control and write data
//   DataOut                  : RAM read data
//   Busy                     : access in progress
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req_0,
  input  logic          Wr_0,
  input  logic          Lock_0,
  input  logic [AW-1:0] Addr_0,
  input  logic [DW-1:0] Wdata_0,
  output logic          Gnt_0,
  output logic          Rvalid_0,
  input  logic          Req_1,
  input  logic          Wr_1,
  input  logic          Lock_1,
  input  logic [AW-1:0] Addr_1,
  input  logic [DW-1:0] Wdata_1,
  output logic          Gnt_1,
  output logic          Rvalid_1,
  output logic [DW-1:0] Rdata,
  output logic          Cs,
  output logic          Wen,
  output logic          Oen,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] DataIn,
  input  logic [DW-1:0] DataOut,
  output logic          Busy
);

  arb_state_e state_q, state_d;

  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  // Index of the current/last winner; doubles as the round-robin pointer.
  logic          win_q, win_d;
  logic          lock_q, lock_d;

  logic [NREQ-1:0] req, winner;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic            cs_q, cs_d;
  logic            wen_q, wen_d;
  logic            oen_q, oen_d;
  logic [AW-1:0]   address_q, address_d;
  logic [DW-1:0]   datain_q, datain_d;
  logic            busy_q, busy_d;

  assign req = {Req_1, Req_0};

  ram_arb_rr u_rr (
    .req    (req),
    .last   (win_q),
    .lock   (lock_q),
    .winner (winner)
  );

  // Next-state and request latching.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    win_d   = win_q;
    lock_d  = lock_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACCESS;
          win_d   = winner[1];
          if (winner[1]) begin
            wr_d    = Wr_1;
            lock_d  = Lock_1;
            addr_d  = Addr_1;
            wdata_d = Wdata_1;
          end else begin
            wr_d    = Wr_0;
            lock_d  = Lock_0;
            addr_d  = Addr_0;
            wdata_d = Wdata_0;
          end
        end
      end
      ACCESS:  state_d = wr_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    gnt_d     = '0;
    rvalid_d  = '0;
    cs_d      = 1'b0;
    wen_d     = 1'b0;
    oen_d     = 1'b0;
    address_d = '0;
    datain_d  = '0;
    busy_d    = (state_d != IDLE);
    if (state_d == ACCESS) begin
      gnt_d[win_d] = 1'b1;
      cs_d         = 1'b1;
      wen_d        = wr_d;
      oen_d        = !wr_d;
      address_d    = addr_d;
      datain_d     = wr_d ? wdata_d : '0;
    end
    if (state_d == RESP) begin
      rvalid_d[win_q] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      win_q     <= 1'b1;  // pretend DMA won last so the CPU wins first
      lock_q    <= 1'b0;
      gnt_q     <= '0;
      rvalid_q  <= '0;
      cs_q      <= 1'b0;
      wen_q     <= 1'b0;
      oen_q     <= 1'b0;
      address_q <= '0;
      datain_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      win_q     <= win_d;
      lock_q    <= lock_d;
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      cs_q      <= cs_d;
      wen_q     <= wen_d;
      oen_q     <= oen_d;
      address_q <= address_d;
      datain_q  <= datain_d;
      busy_q    <= busy_d;
    end
  end

  assign Gnt_0    = gnt_q[0];
  assign Gnt_1    = gnt_q[1];
  assign Rvalid_0 = rvalid_q[0];
  assign Rvalid_1 = rvalid_q[1];
  assign Cs       = cs_q;
  assign Wen      = wen_q;
  assign Oen      = oen_q;
  assign Address  = address_q;
  assign DataIn   = datain_q;
  assign Busy     = busy_q;
  // RAM data is only presented while a read response is valid.
  assign Rdata    = (|rvalid_q) ? DataOut : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural synchronous RAM, per-requester
// command queues driven until granted, and a scoreboard of expected accesses/reads.
module tb_ram_arbiter;

  logic       Clk;
  logic       Rst;
  logic       Req_0, Wr_0, Lock_0, Gnt_0, Rvalid_0;
  logic [7:0] Addr_0, Wdata_0;
  logic       Req_1, Wr_1, Lock_1, Gnt_1, Rvalid_1;
  logic [7:0] Addr_1, Wdata_1;
  logic [7:0] Rdata, Address, DataIn, DataOut;
  logic       Cs, Wen, Oen, Busy;

  typedef struct {
    int       id;
    bit       wr;
    bit       lock;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t cpu_q[$];
  cmd_t dma_q[$];
  cmd_t acc_q[$];
  cmd_t rd_q[$];

  int n_cmp       = 0;
  int n_fail      = 0;
  int cycle       = 0;
  int last_cs_cyc = -1;
  int exp_gap     = 0;

  logic [7:0] mem [256];

  ram_arbiter #(
    .DW (8),
    .AW (8)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Req_0    (Req_0),
    .Wr_0     (Wr_0),
    .Lock_0   (Lock_0),
    .Addr_0   (Addr_0),
    .Wdata_0  (Wdata_0),
    .Gnt_0    (Gnt_0),
    .Rvalid_0 (Rvalid_0),
    .Req_1    (Req_1),
    .Wr_1     (Wr_1),
    .Lock_1   (Lock_1),
    .Addr_1   (Addr_1),
    .Wdata_1  (Wdata_1),
    .Gnt_1    (Gnt_1),
    .Rvalid_1 (Rvalid_1),
    .Rdata    (Rdata),
    .Cs       (Cs),
    .Wen      (Wen),
    .Oen      (Oen),
    .Address  (Address),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .Busy     (Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Synchronous RAM: read data appears the edge after the Oen cycle.
  always @(posedge Clk) begin
    if (Cs && Wen) mem[Address] <= DataIn;
    if (Cs && Oen) DataOut <= mem[Address];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input int id, input bit wr, input bit lock,
                              input logic [7:0] addr, input logic [7:0] data);
    cmd_t c;
    c.id   = id;
    c.wr   = wr;
    c.lock = lock;
    c.addr = addr;
    c.data = data;
    return c;
  endfunction

  task automatic issue(input cmd_t c);
    if (c.id == 0) cpu_q.push_back(c);
    else dma_q.push_back(c);
  endtask

  task automatic present();
    if (cpu_q.size() != 0) begin
      Req_0   = 1'b1;
      Wr_0    = cpu_q[0].wr;
      Lock_0  = cpu_q[0].lock;
      Addr_0  = cpu_q[0].addr;
      Wdata_0 = cpu_q[0].wr ? cpu_q[0].data : ~cpu_q[0].data;
    end else begin
      Req_0  = 1'b0;
      Lock_0 = 1'b0;
    end
    if (dma_q.size() != 0) begin
      Req_1   = 1'b1;
      Wr_1    = dma_q[0].wr;
      Lock_1  = dma_q[0].lock;
      Addr_1  = dma_q[0].addr;
      Wdata_1 = dma_q[0].wr ? dma_q[0].data : ~dma_q[0].data;
    end else begin
      Req_1  = 1'b0;
      Lock_1 = 1'b0;
    end
  endtask

  task automatic check_outputs();
    cmd_t e;
    if (Cs) begin
      chk("acc_expected", 32'(acc_q.size() != 0), 32'd1);
      if (acc_q.size() != 0) begin
        e = acc_q.pop_front();
        chk("gnt", 32'({Gnt_1, Gnt_0}), (e.id == 1) ? 32'd2 : 32'd1);
        chk("wen", 32'(Wen), 32'(e.wr));
        chk("oen", 32'(Oen), 32'(!e.wr));
        chk("address", 32'(Address), 32'(e.addr));
        chk("datain", 32'(DataIn), e.wr ? 32'(e.data) : 32'd0);
        if (!e.wr) rd_q.push_back(e);
        if (exp_gap != 0 && last_cs_cyc >= 0) chk("grant_gap", cycle - last_cs_cyc, exp_gap);
      end
      last_cs_cyc = cycle;
    end else begin
      chk("idle_bus", 32'({Gnt_1, Gnt_0, Wen, Oen, Address, DataIn}), 32'd0);
    end
    if (Rvalid_0 || Rvalid_1) begin
      chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        e = rd_q.pop_front();
        chk("rvalid", 32'({Rvalid_1, Rvalid_0}), (e.id == 1) ? 32'd2 : 32'd1);
        chk("rdata", 32'(Rdata), 32'(e.data));
      end
    end
    chk("busy", 32'(Busy), 32'(Cs || Rvalid_0 || Rvalid_1));
  endtask

  // One clock: sample at the falling edge, retire granted commands, drive the next ones.
  task automatic cyc();
    logic g0, g1;
    @(negedge Clk);
    cycle++;
    g0 = Gnt_0;
    g1 = Gnt_1;
    check_outputs();
    if (g0 && cpu_q.size() != 0) cpu_q.delete(0);
    if (g1 && dma_q.size() != 0) dma_q.delete(0);
    present();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((cpu_q.size() != 0 || dma_q.size() != 0 || acc_q.size() != 0 ||
            rd_q.size() != 0 || Busy) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
    if (n >= budget) begin
      cpu_q.delete();
      dma_q.delete();
      acc_q.delete();
      rd_q.delete();
    end
    cyc();
  endtask

  initial begin
    cmd_t a, b, c, d, e;
    Rst = 1'b1;
    Req_0 = 1'b0; Wr_0 = 1'b0; Lock_0 = 1'b0; Addr_0 = '0; Wdata_0 = '0;
    Req_1 = 1'b0; Wr_1 = 1'b0; Lock_1 = 1'b0; Addr_1 = '0; Wdata_1 = '0;
    repeat (3) cyc();
    chk("reset_outputs", 32'({Gnt_1, Gnt_0, Rvalid_1, Rvalid_0, Cs, Wen, Oen, Busy,
                              Address, DataIn, Rdata}), 32'd0);
    Rst = 1'b0;
    cyc();

    // Single CPU write, then read it back.
    a = mk(0, 1'b1, 1'b0, 8'h12, 8'hA5);
    issue(a); acc_q.push_back(a); drain(20);
    a = mk(0, 1'b0, 1'b0, 8'h12, 8'hA5);
    issue(a); acc_q.push_back(a); drain(20);
    // DMA read of the same location leaves DMA as last winner.
    a = mk(1, 1'b0, 1'b0, 8'h12, 8'hA5);
    issue(a); acc_q.push_back(a); drain(20);

    // Both streaming writes: strict alternation starting with CPU, 2 cycles apart.
    last_cs_cyc = -1;
    exp_gap     = 2;
    a = mk(0, 1'b1, 1'b0, 8'h40, 8'h11);
    b = mk(0, 1'b1, 1'b0, 8'h40, 8'h22);
    c = mk(1, 1'b1, 1'b0, 8'h41, 8'h33);
    d = mk(1, 1'b1, 1'b0, 8'h41, 8'h44);
    issue(a); issue(b); issue(c); issue(d);
    acc_q.push_back(a); acc_q.push_back(c); acc_q.push_back(b); acc_q.push_back(d);
    drain(40);

    // Lock on a DMA grant keeps DMA for exactly one more contention.
    last_cs_cyc = -1;
    a = mk(0, 1'b1, 1'b0, 8'h50, 8'h01);
    b = mk(0, 1'b1, 1'b0, 8'h50, 8'h02);
    c = mk(1, 1'b1, 1'b1, 8'h60, 8'h03);
    d = mk(1, 1'b1, 1'b0, 8'h61, 8'h04);
    e = mk(1, 1'b1, 1'b0, 8'h62, 8'h05);
    issue(a); issue(b); issue(c); issue(d); issue(e);
    acc_q.push_back(a); acc_q.push_back(c); acc_q.push_back(d);
    acc_q.push_back(b); acc_q.push_back(e);
    drain(60);
    exp_gap = 0;

    // Address sweep: CPU writes data = address, then CPU and DMA both read it back.
    // The CPU write makes CPU last winner, so DMA wins the read contention.
    for (int i = 0; i < 255; i++) begin
      a = mk(0, 1'b1, 1'b0, 8'(i), 8'(i));
      issue(a); acc_q.push_back(a); drain(20);
      a = mk(0, 1'b0, 1'b0, 8'(i), 8'(i));
      b = mk(1, 1'b0, 1'b0, 8'(i), 8'(i));
      issue(a); issue(b);
      acc_q.push_back(b); acc_q.push_back(a);
      drain(20);
    end

    // Reset during the ACCESS cycle of a read: k=0 CPU read, k=1 locked DMA read.
    for (int k = 0; k < 2; k++) begin
      a = mk(k, 1'b0, k == 1, 8'(8'h20 + k), 8'(8'h20 + k));
      issue(a); acc_q.push_back(a);
      cyc();
      for (int n = 0; n < 10 && !Cs; n++) cyc();
      chk("abort_in_access", 32'(Cs), 32'd1);
      Rst = 1'b1;
      cyc();
      chk("abort_cs", 32'(Cs), 32'd0);
      chk("abort_rvalid", 32'({Rvalid_1, Rvalid_0}), 32'd0);
      chk("abort_busy", 32'(Busy), 32'd0);
      rd_q.delete();
      acc_q.delete();
      cpu_q.delete();
      dma_q.delete();
      Rst = 1'b0;
      cyc();
      a = mk(0, 1'b1, 1'b0, 8'h70, 8'h5A);
      b = mk(1, 1'b1, 1'b0, 8'h71, 8'hC3);
      issue(a); issue(b);
      acc_q.push_back(a); acc_q.push_back(b);
      drain(20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
